// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and types for the data memory arbiter slice.
package mem_arb_pkg;

    // Requester indices into the grant vector.
    localparam int REQ_CPU = 0;
    localparam int REQ_LDR = 1;

    // Default geometry.
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 3;

    // Which requester owns the memory port this cycle.
    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_CPU  = 2'd1,
        WIN_LDR  = 2'd2
    } win_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface data_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0_i;
    logic              req1_i;
    logic              we0_i;
    logic              we1_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic              gnt0_o;
    logic              gnt1_o;
    logic [DATA_W-1:0] rdata0_o;
    logic [DATA_W-1:0] rdata1_o;
    logic              rvalid0_o;
    logic              rvalid1_o;
    logic              stall0_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Arbiter side.
    modport slave (
        input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i,
               wdata0_i, wdata1_i, mem_rdata_i,
        output gnt0_o, gnt1_o, rdata0_o, rdata1_o, rvalid0_o, rvalid1_o,
               stall0_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
    );

    // Requesters plus memory model side.
    modport master (
        output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i,
               wdata0_i, wdata1_i, mem_rdata_i,
        input  gnt0_o, gnt1_o, rdata0_o, rdata1_o, rvalid0_o, rvalid1_o,
               stall0_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
    );

endinterface

// File: rtl/data_mem_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles the loader has been denied.
// force_pri tells the arbiter to hand the port to the loader this cycle.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic gnt_i,
    output logic force_pri_o
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count denied cycles; any grant or a dropped request restarts the wait.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (gnt_i || !req_i) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign force_pri_o = (wait_cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester data memory arbiter: CPU has fixed priority, the loader is
// guaranteed service after MAX_WAIT denied cycles. Grant is same-cycle,
// read data comes back registered one cycle later.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    data_mem_arbiter_if.slave   bus
);
    logic       force_pri;
    logic [1:0] gnt;
    win_e       win;
    logic       win_we;

    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (bus.req1_i),
        .gnt_i       (gnt[REQ_LDR]),
        .force_pri_o (force_pri)
    );

    // Winner select; reset suppresses every grant.
    always_comb begin
        win = WIN_NONE;
        if (!rst_i) begin
            if (bus.req1_i && (!bus.req0_i || force_pri)) begin
                win = WIN_LDR;
            end else if (bus.req0_i) begin
                win = WIN_CPU;
            end
        end
    end

    assign gnt[REQ_CPU] = (win == WIN_CPU);
    assign gnt[REQ_LDR] = (win == WIN_LDR);

    assign bus.gnt0_o   = gnt[REQ_CPU];
    assign bus.gnt1_o   = gnt[REQ_LDR];
    assign bus.stall0_o = bus.req0_i & ~gnt[REQ_CPU] & ~rst_i;

    // Memory port mux; an idle port drives zeros so nothing leaks onto the bus.
    always_comb begin
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        win_we          = 1'b0;
        case (win)
            WIN_CPU: begin
                bus.mem_addr_o  = bus.addr0_i;
                bus.mem_wdata_o = bus.wdata0_i;
                win_we          = bus.we0_i;
            end
            WIN_LDR: begin
                bus.mem_addr_o  = bus.addr1_i;
                bus.mem_wdata_o = bus.wdata1_i;
                win_we          = bus.we1_i;
            end
            default: ;
        endcase
    end

    assign bus.mem_read_o  = (win != WIN_NONE) & ~win_we;
    assign bus.mem_write_o = (win != WIN_NONE) &  win_we;

    // Capture read data for the granted reader; rdata holds until its next read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt[REQ_CPU] & ~bus.we0_i;
            rvalid1_q <= gnt[REQ_LDR] & ~bus.we1_i;
            if (gnt[REQ_CPU] && !bus.we0_i) begin
                rdata0_q <= bus.mem_rdata_i;
            end
            if (gnt[REQ_LDR] && !bus.we1_i) begin
                rdata1_q <= bus.mem_rdata_i;
            end
        end
    end

    // A return pending when reset arrives is discarded in that same cycle.
    assign bus.rvalid0_o = rvalid0_q & ~rst_i;
    assign bus.rvalid1_o = rvalid1_q & ~rst_i;
    assign bus.rdata0_o  = rst_i ? '0 : rdata0_q;
    assign bus.rdata1_o  = rst_i ? '0 : rdata1_q;

endmodule
